// File: rtl/memory_port_arbiter_if.sv
// rtl/memory_port_arbiter_if.sv - requester and bram port bundle for memory_port_arbiter
interface memory_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  f_req;
  logic [ADDR_WIDTH-1:0] f_addr;
  logic                  f_done;
  logic                  d_req;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic                  d_write;
  logic [3:0]            d_byte_en;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_done;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic                  busy;
  logic                  mem_input_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_write_enable;
  logic [3:0]            mem_byte_enable;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_done_or_valid;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  f_req, f_addr, d_req, d_addr, d_write, d_byte_en, d_wdata,
    input  mem_done_or_valid, mem_read_data,
    output f_done, d_done, rdata, err, busy,
    output mem_input_enable, mem_address, mem_write_enable, mem_byte_enable, mem_write_data
  );

  modport master (
    output f_req, f_addr, d_req, d_addr, d_write, d_byte_en, d_wdata,
    output mem_done_or_valid, mem_read_data,
    input  f_done, d_done, rdata, err, busy,
    input  mem_input_enable, mem_address, mem_write_enable, mem_byte_enable, mem_write_data
  );
endinterface

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - round-robin fetch/load-store arbiter for a single bram port
// with a watchdog that aborts transactions the memory never acknowledges.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  memory_port_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
  localparam logic GRANT_F = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t                state_q, state_n;
  logic                  owner_q, owner_n;
  logic                  last_q, last_n;
  logic [15:0]           cnt_q, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  we_q, we_n;
  logic [3:0]            be_q, be_n;
  logic [DATA_WIDTH-1:0] wd_q, wd_n;
  logic [DATA_WIDTH-1:0] cap_q, cap_n;
  logic                  err_q, err_n;
  logic                  pick_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= GRANT_F;
      last_q  <= GRANT_F;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wd_q    <= '0;
      cap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      cnt_q   <= cnt_n;
      addr_q  <= addr_n;
      we_q    <= we_n;
      be_q    <= be_n;
      wd_q    <= wd_n;
      cap_q   <= cap_n;
      err_q   <= err_n;
    end
  end

  // On a tie the side that did not win last time takes the port.
  assign pick_d = bus.d_req & (~bus.f_req | (last_q == GRANT_F));

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    addr_n  = addr_q;
    we_n    = we_q;
    be_n    = be_q;
    wd_n    = wd_q;
    cap_n   = cap_q;
    err_n   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.f_req || bus.d_req) begin
          owner_n = pick_d;
          last_n  = pick_d;
          if (pick_d) begin
            addr_n = bus.d_addr;
            we_n   = bus.d_write;
            be_n   = bus.d_byte_en;
            wd_n   = bus.d_wdata;
          end else begin
            addr_n = bus.f_addr;
            we_n   = 1'b0;
            be_n   = 4'b0000;
            wd_n   = '0;
          end
          state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_n   = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // An ack arriving on the limit cycle still completes normally.
        if (bus.mem_done_or_valid) begin
          cap_n   = bus.mem_read_data;
          err_n   = 1'b0;
          state_n = S_RESPOND;
        end else if (cnt_q == TMO) begin
          cap_n   = '0;
          err_n   = 1'b1;
          state_n = S_RESPOND;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
      end
      S_RESPOND: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign bus.mem_input_enable = (state_q == S_ISSUE);
  assign bus.busy             = (state_q != S_IDLE);
  assign bus.f_done           = (state_q == S_RESPOND) && (owner_q == GRANT_F);
  assign bus.d_done           = (state_q == S_RESPOND) && (owner_q == GRANT_D);
  assign bus.rdata            = (state_q == S_RESPOND) ? cap_q : '0;
  assign bus.err              = (state_q == S_RESPOND) && err_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_enable = we_q;
  assign bus.mem_byte_enable  = be_q;
  assign bus.mem_write_data   = wd_q;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ie_cnt = 0;
  int   ie_mark;
  logic [31:0] gnt_addr [4];

  memory_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  memory_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock(clk),
    .reset(resetn),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_input_enable === 1'b1) ie_cnt <= ie_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_f_done"}, 64'(bus.f_done), 64'd0);
    check({tag, "_d_done"}, 64'(bus.d_done), 64'd0);
    check({tag, "_rdata"}, 64'(bus.rdata), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_mie"}, 64'(bus.mem_input_enable), 64'd0);
  endtask

  initial begin
    bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_addr = 0;
    bus.d_write = 0; bus.d_byte_en = 0; bus.d_wdata = 0;
    bus.mem_done_or_valid = 0; bus.mem_read_data = 0;

    // reset state
    tick(); tick();
    check_idle_outputs("rst");
    check("rst_addr", 64'(bus.mem_address), 64'd0);
    check("rst_we", 64'(bus.mem_write_enable), 64'd0);
    check("rst_be", 64'(bus.mem_byte_enable), 64'd0);
    check("rst_wd", 64'(bus.mem_write_data), 64'd0);
    resetn = 1;
    tick();

    // single load, ack on second WAIT cycle
    ie_mark = ie_cnt;
    bus.d_req = 1; bus.d_addr = 32'h40;
    tick();
    check("ld_mie", 64'(bus.mem_input_enable), 64'd1);
    check("ld_addr", 64'(bus.mem_address), 64'h40);
    check("ld_busy", 64'(bus.busy), 64'd1);
    tick();
    check("ld_mie_off", 64'(bus.mem_input_enable), 64'd0);
    check("ld_nodone", 64'(bus.d_done), 64'd0);
    tick();
    bus.mem_done_or_valid = 1; bus.mem_read_data = 32'hDEADBEEF;
    tick();
    check("ld_d_done", 64'(bus.d_done), 64'd1);
    check("ld_f_done", 64'(bus.f_done), 64'd0);
    check("ld_rdata", 64'(bus.rdata), 64'hDEADBEEF);
    check("ld_err", 64'(bus.err), 64'd0);
    bus.d_req = 0; bus.mem_done_or_valid = 0;
    tick();
    check_idle_outputs("ld_after");
    check("ld_ie_count", 64'(ie_cnt - ie_mark), 64'd1);
    check("ld_addr_hold", 64'(bus.mem_address), 64'h40);

    // simultaneous requests after reset: d, f, d, f
    resetn = 0; tick(); resetn = 1;
    gnt_addr[0] = 32'h200; gnt_addr[1] = 32'h100;
    gnt_addr[2] = 32'h200; gnt_addr[3] = 32'h100;
    bus.f_req = 1; bus.f_addr = 32'h100;
    bus.d_req = 1; bus.d_addr = 32'h200;
    bus.mem_done_or_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.mem_read_data = 32'hA0 + 32'(i);
      tick();
      check($sformatf("rr%0d_mie", i), 64'(bus.mem_input_enable), 64'd1);
      check($sformatf("rr%0d_addr", i), 64'(bus.mem_address), 64'(gnt_addr[i]));
      tick();
      check($sformatf("rr%0d_wait_nodone", i), 64'(bus.f_done | bus.d_done), 64'd0);
      tick();
      check($sformatf("rr%0d_d_done", i), 64'(bus.d_done), 64'((i % 2) == 0));
      check($sformatf("rr%0d_f_done", i), 64'(bus.f_done), 64'((i % 2) == 1));
      check($sformatf("rr%0d_rdata", i), 64'(bus.rdata), 64'(32'hA0 + 32'(i)));
      tick();
      check($sformatf("rr%0d_idle", i), 64'(bus.busy), 64'd0);
    end
    bus.f_req = 0; bus.d_req = 0; bus.mem_done_or_valid = 0;
    tick();

    // store with inputs scrambled after grant
    bus.d_req = 1; bus.d_addr = 32'h80; bus.d_write = 1;
    bus.d_byte_en = 4'b0011; bus.d_wdata = 32'h12345678;
    tick();
    bus.d_addr = 32'hFFFF_FFFF; bus.d_write = 0;
    bus.d_byte_en = 4'b1100; bus.d_wdata = 32'hBADBAD00;
    check("st_mie", 64'(bus.mem_input_enable), 64'd1);
    check("st_we", 64'(bus.mem_write_enable), 64'd1);
    check("st_be", 64'(bus.mem_byte_enable), 64'b0011);
    check("st_wd", 64'(bus.mem_write_data), 64'h12345678);
    tick(); tick();
    check("st_we_wait", 64'(bus.mem_write_enable), 64'd1);
    check("st_be_wait", 64'(bus.mem_byte_enable), 64'b0011);
    check("st_wd_wait", 64'(bus.mem_write_data), 64'h12345678);
    check("st_addr_wait", 64'(bus.mem_address), 64'h80);
    bus.mem_done_or_valid = 1; bus.mem_read_data = 32'h55;
    tick();
    check("st_d_done", 64'(bus.d_done), 64'd1);
    check("st_err", 64'(bus.err), 64'd0);
    bus.d_req = 0; bus.mem_done_or_valid = 0;
    bus.d_write = 0; bus.d_byte_en = 0; bus.d_wdata = 0; bus.d_addr = 0;
    tick();
    check("st_wd_idle", 64'(bus.mem_write_data), 64'h12345678);

    // fetch timeout: 5 WAIT cycles then RESPOND 6 cycles after ISSUE
    bus.f_req = 1; bus.f_addr = 32'h300; bus.mem_read_data = 32'hCAFEF00D;
    tick();
    check("to_mie", 64'(bus.mem_input_enable), 64'd1);
    check("to_we", 64'(bus.mem_write_enable), 64'd0);
    check("to_be", 64'(bus.mem_byte_enable), 64'd0);
    check("to_wd", 64'(bus.mem_write_data), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("to_wait%0d_nodone", i), 64'(bus.f_done), 64'd0);
    end
    tick();
    check("to_f_done", 64'(bus.f_done), 64'd1);
    check("to_err", 64'(bus.err), 64'd1);
    check("to_rdata", 64'(bus.rdata), 64'd0);
    bus.f_req = 0;
    tick();

    // ack on 4th WAIT cycle
    bus.f_req = 1;
    tick(); tick(); tick(); tick(); tick();
    bus.mem_done_or_valid = 1; bus.mem_read_data = 32'h1111_2222;
    tick();
    check("a4_f_done", 64'(bus.f_done), 64'd1);
    check("a4_err", 64'(bus.err), 64'd0);
    check("a4_rdata", 64'(bus.rdata), 64'h1111_2222);
    bus.f_req = 0; bus.mem_done_or_valid = 0;
    tick();

    // ack on the limit cycle (5th WAIT) still wins over the timeout
    bus.f_req = 1;
    tick(); tick(); tick(); tick(); tick(); tick();
    bus.mem_done_or_valid = 1; bus.mem_read_data = 32'h3333_4444;
    tick();
    check("a5_f_done", 64'(bus.f_done), 64'd1);
    check("a5_err", 64'(bus.err), 64'd0);
    check("a5_rdata", 64'(bus.rdata), 64'h3333_4444);
    bus.f_req = 0; bus.mem_done_or_valid = 0;
    tick();

    // reset mid-WAIT after a load/store grant
    bus.d_req = 1; bus.d_addr = 32'h500; bus.d_write = 1;
    bus.d_byte_en = 4'b1111; bus.d_wdata = 32'h9;
    tick(); tick();
    check("rw_busy", 64'(bus.busy), 64'd1);
    resetn = 0; bus.d_req = 0; bus.d_write = 0; bus.mem_done_or_valid = 1;
    tick();
    check_idle_outputs("rw");
    check("rw_addr", 64'(bus.mem_address), 64'd0);
    check("rw_we", 64'(bus.mem_write_enable), 64'd0);
    resetn = 1; bus.mem_done_or_valid = 0;
    ie_mark = ie_cnt;
    tick(); tick();
    check_idle_outputs("rw_post");
    check("rw_no_ie", 64'(ie_cnt - ie_mark), 64'd0);
    bus.f_req = 1; bus.f_addr = 32'h600;
    bus.d_req = 1; bus.d_addr = 32'h700;
    tick();
    check("rw_tie_addr", 64'(bus.mem_address), 64'h700);
    bus.mem_done_or_valid = 1; bus.mem_read_data = 32'h77;
    tick(); tick();
    check("rw_d_done", 64'(bus.d_done), 64'd1);
    check("rw_f_done", 64'(bus.f_done), 64'd0);
    bus.f_req = 0; bus.d_req = 0; bus.mem_done_or_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
